emotion_mux_fade: RTL and testbench

//   N-channel pixel selector that replaces the combinational 4:1 emotion mux in

---
 rtl/emotion_mux_fade.sv | 148 ++++++++++++++
 tb/tb_emotion_mux_fade.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/emotion_mux_fade.sv
// Frame-synchronous N-channel pixel selector with optional per-component
// crossfade between the outgoing and incoming channel; 2-cycle latency.
module emotion_mux_fade #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 12,
  parameter int FADE_LOG2 = 4,
  parameter int RESET_SEL = 0,
  parameter int SEL_W     = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_frame_start,
  output logic [DATA_W-1:0]        o_color_data,
  output logic [SEL_W-1:0]         o_active_sel,
  output logic                     o_fading
);

  localparam int CW = DATA_W / 3;
  localparam int KW = FADE_LOG2 + 1;
  localparam int PW = CW + FADE_LOG2 + 1;
  localparam logic [KW-1:0] KMAX = KW'((1 << FADE_LOG2) - 1);
  localparam logic [KW-1:0] KONE = KW'(1 << FADE_LOG2);
  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(RESET_SEL);

  typedef enum logic {
    IDLE,
    FADE
  } state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic [SEL_W-1:0]  old_q, old_d;
  logic [SEL_W-1:0]  new_q, new_d;
  logic [SEL_W-1:0]  pend_q, pend_d;
  logic              pvld_q, pvld_d;

  logic [SEL_W-1:0]  tgt;
  logic [SEL_W-1:0]  sa;
  logic              sel_ok;
  logic [DATA_W-1:0] a_q, b_q, out_q, blend;
  logic [KW-1:0]     kp_q;

  assign tgt    = (state_q == FADE) ? new_q : cur_q;
  assign sa     = (state_q == FADE) ? old_q : cur_q;
  assign sel_ok = int'(i_sel) < NUM_CH;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cur_d   = cur_q;
    old_d   = old_q;
    new_d   = new_q;
    pend_d  = pend_q;
    pvld_d  = pvld_q;
    unique case (state_q)
      IDLE: begin
        if (i_frame_start && pvld_q) begin
          old_d  = cur_q;
          new_d  = pend_q;
          pvld_d = 1'b0;
          if (FADE_LOG2 == 0) begin
            cur_d = pend_q;
          end else begin
            k_d     = KW'(1);
            state_d = FADE;
          end
        end
      end
      FADE: begin
        if (i_frame_start) begin
          if (k_q == KMAX) begin
            cur_d   = new_q;
            k_d     = '0;
            state_d = IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh request overrides the slot the frame start just consumed
    if (sel_ok) begin
      if (i_sel == tgt) begin
        pvld_d = 1'b0;
      end else begin
        pend_d = i_sel;
        pvld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cur_q   <= RST_SEL;
      old_q   <= RST_SEL;
      new_q   <= RST_SEL;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cur_q   <= cur_d;
      old_q   <= old_d;
      new_q   <= new_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      kp_q  <= '0;
      out_q <= '0;
    end else begin
      a_q   <= i_data[int'(sa)*DATA_W +: DATA_W];
      b_q   <= i_data[int'(tgt)*DATA_W +: DATA_W];
      kp_q  <= k_q;
      out_q <= blend;
    end
  end

  always_comb begin
    logic [PW-1:0] pa, pb, sum;
    blend = '0;
    pa    = '0;
    pb    = '0;
    sum   = '0;
    for (int c = 0; c < 3; c++) begin
      pa  = PW'(a_q[c*CW +: CW]) * PW'(KONE - kp_q);
      pb  = PW'(b_q[c*CW +: CW]) * PW'(kp_q);
      sum = pa + pb;
      blend[c*CW +: CW] = CW'(sum >> FADE_LOG2);
    end
  end

  assign o_color_data = out_q;
  assign o_active_sel = tgt;
  assign o_fading     = (state_q == FADE);

endmodule

// File: tb/tb_emotion_mux_fade.sv
// Bench for emotion_mux_fade: a 4-channel fading instance and a
// 3-channel hard-switch instance share stimulus and a reference model.
module tb_emotion_mux_fade;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] data;
  logic [1:0]  sel;
  logic        fs;
  logic [11:0] out0, out1;
  logic [1:0]  act0, act1;
  logic        fad0, fad1;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  emotion_mux_fade #(
    .NUM_CH(4), .DATA_W(12), .FADE_LOG2(4), .RESET_SEL(0)
  ) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_sel(sel),
    .i_frame_start(fs), .o_color_data(out0),
    .o_active_sel(act0), .o_fading(fad0)
  );

  emotion_mux_fade #(
    .NUM_CH(3), .DATA_W(12), .FADE_LOG2(0), .RESET_SEL(0)
  ) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[35:0]), .i_sel(sel),
    .i_frame_start(fs), .o_color_data(out1),
    .o_active_sel(act1), .o_fading(fad1)
  );

  // reference model: instance 0 = 4 ch / 16 frames, 1 = 3 ch / hard
  int m_nch[2] = '{4, 3};
  int m_l[2]   = '{4, 0};
  int m_cur[2], m_new[2], m_old[2], m_pend[2], m_k[2];
  bit m_fad[2];
  logic [11:0] q0[$];
  logic [11:0] q1[$];

  typedef struct {
    logic [1:0]  sel;
    logic        fs;
    logic [11:0] exp_out;
    logic [1:0]  exp_act;
  } vec_t;
  vec_t tv[14];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] chan(int c);
    return data[c*12 +: 12];
  endfunction

  function automatic logic [11:0] mblend(logic [11:0] a, logic [11:0] b,
                                         int k, int l);
    logic [11:0] r;
    int av, bv;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      av = int'(a[c*4 +: 4]);
      bv = int'(b[c*4 +: 4]);
      r[c*4 +: 4] = 4'((av * ((1 << l) - k) + bv * k) >> l);
    end
    return r;
  endfunction

  function automatic logic [11:0] mpix(int m);
    if (m_fad[m]) return mblend(chan(m_old[m]), chan(m_new[m]), m_k[m], m_l[m]);
    return chan(m_cur[m]);
  endfunction

  function automatic int mact(int m);
    return m_fad[m] ? m_new[m] : m_cur[m];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cur[m] = 0; m_new[m] = 0; m_old[m] = 0;
      m_pend[m] = -1; m_k[m] = 0; m_fad[m] = 1'b0;
    end
    q0.delete(); q0.push_back(12'h0);
    q1.delete(); q1.push_back(12'h0);
  endtask

  task automatic model_edge(int m);
    int tgt, p, s;
    tgt = mact(m);
    p   = m_pend[m];
    s   = int'(sel);
    if (fs) begin
      if (!m_fad[m] && p >= 0) begin
        m_old[m] = m_cur[m];
        m_new[m] = p;
        p = -1;
        if (m_l[m] == 0) m_cur[m] = m_new[m];
        else begin m_fad[m] = 1'b1; m_k[m] = 1; end
      end else if (m_fad[m]) begin
        if (m_k[m] == (1 << m_l[m]) - 1) begin
          m_cur[m] = m_new[m]; m_fad[m] = 1'b0; m_k[m] = 0;
        end else m_k[m]++;
      end
    end
    if (s < m_nch[m]) p = (s == tgt) ? -1 : s;
    m_pend[m] = p;
  endtask

  task automatic step();
    logic [11:0] e0, e1;
    if (rst_n) begin
      q0.push_back(mpix(0));
      q1.push_back(mpix(1));
      model_edge(0);
      model_edge(1);
    end
    @(posedge clk);
    @(negedge clk);
    e0 = 12'h0;
    e1 = 12'h0;
    if (rst_n) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
    end
    chk("m0_out", 32'(out0), 32'(e0));
    chk("m0_act", 32'(act0), 32'(mact(0)));
    chk("m0_fad", 32'(fad0), 32'(m_fad[0]));
    chk("m1_out", 32'(out1), 32'(e1));
    chk("m1_act", 32'(act1), 32'(mact(1)));
    chk("m1_fad", 32'(fad1), 32'(m_fad[1]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  task automatic frame();
    fs = 1'b1;
    step();
    fs = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    tv[0]  = '{2'd0, 1'b0, 12'h000, 2'd0};
    tv[1]  = '{2'd0, 1'b0, 12'hF00, 2'd0};
    tv[2]  = '{2'd2, 1'b0, 12'hF00, 2'd0};
    tv[3]  = '{2'd2, 1'b0, 12'hF00, 2'd0};
    tv[4]  = '{2'd2, 1'b1, 12'hF00, 2'd2};
    tv[5]  = '{2'd2, 1'b0, 12'hF00, 2'd2};
    tv[6]  = '{2'd3, 1'b0, 12'h00F, 2'd2};
    tv[7]  = '{2'd3, 1'b1, 12'h00F, 2'd2};
    tv[8]  = '{2'd2, 1'b1, 12'h00F, 2'd2};
    tv[9]  = '{2'd1, 1'b1, 12'h00F, 2'd2};
    tv[10] = '{2'd1, 1'b0, 12'h00F, 2'd2};
    tv[11] = '{2'd1, 1'b1, 12'h00F, 2'd1};
    tv[12] = '{2'd1, 1'b0, 12'h00F, 2'd1};
    tv[13] = '{2'd1, 1'b0, 12'h0F0, 2'd1};

    rst_n = 1'b0;
    sel   = 2'd0;
    fs    = 1'b0;
    data  = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out", 32'(out0), 32'h000);
    chk("rst_act", 32'(act0), 32'd0);
    chk("rst_fad", 32'(fad0), 32'd0);
    rst_n = 1'b1;

    // hard switch, out-of-range and same-channel requests
    for (int i = 0; i < 14; i++) begin
      sel = tv[i].sel;
      fs  = tv[i].fs;
      step();
      chk("tv_out", 32'(out1), 32'(tv[i].exp_out));
      chk("tv_act", 32'(act1), 32'(tv[i].exp_act));
    end
    fs = 1'b0;

    // 16-frame crossfade 0 -> 3
    do_reset();
    data = {12'h008, 12'h00F, 12'h0F0, 12'h800};
    sel  = 2'd3;
    step();
    step();
    for (int i = 0; i < 8; i++) frame();
    chk("k8_out", 32'(out0), 32'h404);
    chk("k8_fad", 32'(fad0), 32'd1);
    chk("k8_act", 32'(act0), 32'd3);
    for (int i = 0; i < 6; i++) frame();
    data = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
    frame();
    chk("k15_out", 32'(out0), 32'hFEE);
    fs = 1'b1;
    step();
    fs = 1'b0;
    chk("end_fad", 32'(fad0), 32'd0);
    step();
    step();
    chk("end_out", 32'(out0), 32'hFFF);

    // requests during a fade are held, latest wins
    do_reset();
    sel = 2'd1;
    step();
    frame();
    chk("f4_act", 32'(act0), 32'd1);
    chk("f4_fad", 32'(fad0), 32'd1);
    sel = 2'd2;
    step();
    sel = 2'd3;
    step();
    for (int i = 0; i < 14; i++) frame();
    chk("f4_act15", 32'(act0), 32'd1);
    frame();
    chk("f4_idle", 32'(fad0), 32'd0);
    chk("f4_held", 32'(act0), 32'd1);
    frame();
    chk("f4_next", 32'(act0), 32'd3);
    chk("f4_nfad", 32'(fad0), 32'd1);

    // asynchronous reset in the middle of a fade
    do_reset();
    sel = 2'd2;
    step();
    for (int i = 0; i < 7; i++) frame();
    rst_n = 1'b0;
    #1;
    chk("ar_out", 32'(out0), 32'h000);
    chk("ar_act", 32'(act0), 32'd0);
    chk("ar_fad", 32'(fad0), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      data = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
      fs = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
